// File: rtl/segment_decoder_if.sv
// Bundles the segment input, enable and decoded-character handshake of segment_decoder.
// The decoder takes the slave view; the producer/consumer side takes the master view.
interface segment_decoder_if;
  logic       enable;
  logic [6:0] segIn;
  logic [6:0] charOut;
  logic       charValid;
  logic       charReady;
  logic       charErr;
  logic       overrun;

  modport master (
    output enable, segIn, charReady,
    input  charOut, charValid, charErr, overrun
  );

  modport slave (
    input  enable, segIn, charReady,
    output charOut, charValid, charErr, overrun
  );
endinterface

// File: rtl/segment_decoder.sv
// Debounces a sampled 7-segment bus, decodes each settled pattern to ASCII and offers it
// on a valid/ready handshake, flagging unknown patterns and dropped characters.
module segment_decoder #(
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned SUPPRESS_REPEAT = 1
) (
  input logic              clk,
  input logic              reset,
  segment_decoder_if.slave bus
);

  typedef enum logic [0:0] {StTrack, StLocked} state_e;

  localparam logic [7:0] CntSettle = 8'(STABLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] seg_q, prev_q;
  logic [6:0] last_q, last_d;
  logic       last_valid_q, last_valid_d;
  logic [6:0] char_q, char_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       settle;
  logic       fire;
  logic [7:0] dec;

  // Returns {err, ascii}.
  function automatic logic [7:0] decode(input logic [6:0] p);
    logic [7:0] r;
    unique case (p)
      7'h3F:   r = {1'b0, 7'h30};
      7'h06:   r = {1'b0, 7'h31};
      7'h5B:   r = {1'b0, 7'h32};
      7'h4F:   r = {1'b0, 7'h33};
      7'h66:   r = {1'b0, 7'h34};
      7'h6D:   r = {1'b0, 7'h35};
      7'h7D:   r = {1'b0, 7'h36};
      7'h07:   r = {1'b0, 7'h37};
      7'h7F:   r = {1'b0, 7'h38};
      7'h6F:   r = {1'b0, 7'h39};
      7'h77:   r = {1'b0, 7'h41};
      7'h7C:   r = {1'b0, 7'h62};
      7'h39:   r = {1'b0, 7'h43};
      7'h5E:   r = {1'b0, 7'h64};
      7'h79:   r = {1'b0, 7'h45};
      7'h71:   r = {1'b0, 7'h46};
      7'h40:   r = {1'b0, 7'h2D};
      7'h00:   r = {1'b0, 7'h20};
      default: r = {1'b1, 7'h3F};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StTrack;
      cnt_q        <= 8'd0;
      seg_q        <= 7'h00;
      prev_q       <= 7'h00;
      last_q       <= 7'h00;
      last_valid_q <= 1'b0;
      char_q       <= 7'h00;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seg_q        <= bus.segIn;
      prev_q       <= seg_q;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      char_q       <= char_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  // While locked, prev_q always equals the locked pattern, so one comparison serves both states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    settle  = 1'b0;
    if (!bus.enable) begin
      state_d = StTrack;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        StTrack: begin
          if (seg_q != prev_q) begin
            cnt_d = 8'd0;
          end else if (cnt_q == CntSettle) begin
            settle  = 1'b1;
            state_d = StLocked;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StLocked: begin
          if (seg_q != prev_q) begin
            state_d = StTrack;
            cnt_d   = 8'd0;
          end
        end
        default: state_d = StTrack;
      endcase
    end
  end

  always_comb begin
    dec          = decode(seg_q);
    fire         = settle && !((SUPPRESS_REPEAT != 0) && last_valid_q && (seg_q == last_q));
    char_d       = char_q;
    err_d        = err_q;
    valid_d      = valid_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    overrun_d    = overrun_q;
    if (valid_q && bus.charReady) begin
      valid_d = 1'b0;
    end
    if (fire) begin
      if (!valid_q || bus.charReady) begin
        char_d       = dec[6:0];
        err_d        = dec[7];
        valid_d      = 1'b1;
        last_d       = seg_q;
        last_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign bus.charOut   = char_q;
  assign bus.charErr   = err_q;
  assign bus.charValid = valid_q;
  assign bus.overrun   = overrun_q;

endmodule
